// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the IF/ID stages and the branch predictor.
// master: fetch PC, resolution and flush out; prediction in. slave: the predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_addr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_jump;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_addr;
  logic              flush;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_jump,
    output upd_taken, upd_addr, flush,
    input  pred_taken, pred_addr
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_jump,
    input  upd_taken, upd_addr, flush,
    output pred_taken, pred_addr
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup.
// Ports: clk, rst (async high), bus (slave). Option: BRANCH_PRED_GSHARE_EN.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int HIST_W  = 6
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];

  logic [IDX_W-1:0]  l_idx, l_cidx, u_idx, u_cidx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              l_hit, u_hit, u_tkn;
  logic [1:0]        u_ctr, ctr_d;
  logic              ctr_we, alloc_we;
  logic [3:0]        unused_pc;

  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc = {bus.lookup_pc[1:0], bus.upd_pc[1:0]};

`ifdef BRANCH_PRED_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  // Only counters are hashed; tag/target stay on the plain index.
  assign l_cidx = l_idx ^ IDX_W'(ghr_q);
  assign u_cidx = u_idx ^ IDX_W'(ghr_q);
  assign ghr_d  = (ghr_q << 1) | HIST_W'(bus.upd_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (bus.flush) begin
      ghr_q <= '0;
    end else if (bus.upd_valid && !bus.upd_jump) begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic [HIST_W-1:0] unused_hist;

  assign unused_hist = '0;
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign bus.pred_taken = l_hit && ctr_q[l_cidx][1];
  assign bus.pred_addr  = bus.pred_taken ? tgt_q[l_idx]
                                         : bus.lookup_pc + ADDR_W'(4);

  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_tkn    = bus.upd_jump || bus.upd_taken;
  assign u_ctr    = ctr_q[u_cidx];
  assign ctr_we   = bus.upd_valid && (u_hit || u_tkn);
  assign alloc_we = bus.upd_valid && u_tkn;

  // Miss reaching here is always a taken allocation.
  always_comb begin
    ctr_d = u_ctr;
    priority case (1'b1)
      bus.upd_jump:  ctr_d = 2'b11;
      !u_hit:        ctr_d = 2'b10;
      bus.upd_taken: ctr_d = (u_ctr == 2'b11) ? u_ctr : u_ctr + 2'd1;
      default:       ctr_d = (u_ctr == 2'b00) ? u_ctr : u_ctr - 2'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      if (ctr_we) ctr_q[u_cidx] <= ctr_d;
      if (alloc_we) valid_q[u_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (alloc_we && !bus.flush) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= bus.upd_addr;
    end
  end
endmodule
